ifid_stall_reg: RTL
===================

// Module: ifid_stall_reg
// PURPOSE
//  IF->ID pipeline register; the consuming end of the jump-stall and full-stall
//  handshakes that ID drives. Turns stall requests into held or NOP-injected
//  slots so ID never decodes a stale or wrong-path instruction after a jump.
//  Sits between the PIF fetch stage and the ID stage.
// PARAMETERS
//  XLEN        32            pc/inst width (matches `COMMON_WIDTH)
//  NOP_INST    32'h0000_0013 encoding injected as a bubble (addi x0,x0,0)
//  DRAIN_NOPS  1             extra NOPs emitted after jump_stall deasserts (1..3)
//  CNT_W       32            width of bubble counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  full_stall   in   1      ID: ROB full; freeze this register completely
//  jump_stall   in   1      ID: possible jump in flight; inject NOPs
//  if_valid     in   1      PIF slot valid
//  if_pc        in   XLEN   PIF pc
//  if_inst      in   XLEN   PIF instruction
//  id_valid     out  1      ID slot holds a real instruction
//  id_pc        out  XLEN   pc presented to ID
//  id_inst      out  XLEN   instruction presented to ID (NOP_INST when bubble)
//  id_bubble    out  1      current slot is an injected NOP
//  bubble_cnt   out  CNT_W  count of injected NOP slots, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): id_valid=0, id_pc=0, id_inst=NOP_INST, id_bubble=1,
//   bubble_cnt=0, state=RUN, drain counter=0. Release takes effect next edge.
//  All outputs registered; latency IF->ID = 1 cycle. No combinational in->out.
//  States: RUN, JSTALL, DRAIN. Evaluated each rising edge, priority order:
//  1 full_stall=1 (any state): hold every output, state, drain counter and
//    bubble_cnt unchanged. Overrides jump_stall; a held real inst is never lost.
//  2 RUN:
//    - jump_stall=1: load bubble, -> JSTALL.
//    - else if_valid=1: load id_pc=if_pc, id_inst=if_inst, id_valid=1, id_bubble=0.
//    - else if_valid=0: id_valid=0, id_inst=NOP_INST, id_pc=if_pc, id_bubble=0
//      (fetch gap, not counted as injection).
//  3 JSTALL: bubble every cycle. jump_stall=0 -> load bubble, drain counter=
//    DRAIN_NOPS-1; -> DRAIN if DRAIN_NOPS>1 else -> RUN. (The cycle that sees
//    jump_stall=0 is itself the first drain NOP; IF data is stale there.)
//  4 DRAIN: bubble; counter decrements; counter==0 -> RUN next. jump_stall=1
//    here -> bubble, -> JSTALL, counter cleared.
//  "load bubble" = id_valid=0, id_inst=NOP_INST, id_pc unchanged, id_bubble=1,
//   bubble_cnt+=1 saturating at all-ones.
//  Simultaneous full_stall release and jump_stall fall: full_stall deasserted
//   edge acts per state rules above with current jump_stall value.
//  Illegal state encoding -> RUN with bubble (safe recovery).
//  Mid-operation reset: immediately returns to reset values, any pending drain
//   NOPs discarded.
// TESTING
//  1 Reset then if_valid=1, pc 0x100..0x10C one per cycle -> id_pc follows 1 cycle
//    later, id_valid=1, bubble_cnt=0.
//  2 RUN, jump_stall high 3 cycles then low, DRAIN_NOPS=1 -> exactly 4 bubble slots
//    (id_inst=0x13, id_valid=0), bubble_cnt=4, then real inst resumes.
//  3 id holds pc 0x200 valid, full_stall high 5 cycles with jump_stall=1 -> id_pc
//    stays 0x200 valid, bubble_cnt unchanged; after release -> bubble, JSTALL.
//  4 DRAIN_NOPS=3, jump_stall pulse 1 cycle -> 4 bubbles; reassert jump_stall in
//    second drain cycle -> stays bubbling, returns to RUN only after new fall + drain.
//  5 rst_n asserted mid-JSTALL (async, between edges) -> outputs reset instantly,
//    next cycle after release with if_valid=1 loads real inst, no drain NOP.
//  6 Force bubble_cnt near all-ones (CNT_W=4) -> saturates at 15, no wrap.

Source files
------------

// File: rtl/ifid_stall_reg.sv
// IF->ID pipeline register that absorbs ID's full-stall and jump-stall requests.
// It holds the slot on a full stall and injects NOP bubbles around a possible jump.
module ifid_stall_reg #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] NOP_INST   = 32'h0000_0013,
  parameter int              DRAIN_NOPS = 1,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             full_stall,
  input  logic             jump_stall,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_inst,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_inst,
  output logic             id_bubble,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_JSTALL = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // The jump_stall fall cycle is itself the first drain NOP, so only DRAIN_NOPS-1 remain.
  localparam logic [1:0]       DRAIN_LOAD   = 2'(DRAIN_NOPS - 1);
  localparam state_t           AFTER_JSTALL = (DRAIN_NOPS > 1) ? ST_DRAIN : ST_RUN;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state_reg, state_next;
  logic [1:0]       drain_reg, drain_next;
  logic             valid_reg, valid_next;
  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [XLEN-1:0]  inst_reg, inst_next;
  logic             bubble_reg, bubble_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load_bubble;

  always_comb begin
    state_next  = state_reg;
    drain_next  = drain_reg;
    valid_next  = valid_reg;
    pc_next     = pc_reg;
    inst_next   = inst_reg;
    bubble_next = bubble_reg;
    cnt_next    = cnt_reg;
    load_bubble = 1'b0;

    if (!full_stall) begin
      case (state_reg)
        ST_RUN: begin
          if (jump_stall) begin
            load_bubble = 1'b1;
            state_next  = ST_JSTALL;
          end else begin
            // A fetch gap is passed through as an invalid slot, not an injected bubble
            valid_next  = if_valid;
            pc_next     = if_pc;
            inst_next   = if_valid ? if_inst : NOP_INST;
            bubble_next = 1'b0;
          end
        end
        ST_JSTALL: begin
          load_bubble = 1'b1;
          if (!jump_stall) begin
            drain_next = DRAIN_LOAD;
            state_next = AFTER_JSTALL;
          end
        end
        ST_DRAIN: begin
          load_bubble = 1'b1;
          if (jump_stall) begin
            drain_next = 2'd0;
            state_next = ST_JSTALL;
          end else begin
            drain_next = (drain_reg == 2'd0) ? 2'd0 : drain_reg - 2'd1;
            if (drain_next == 2'd0) begin
              state_next = ST_RUN;
            end
          end
        end
        default: begin
          load_bubble = 1'b1;
          drain_next  = 2'd0;
          state_next  = ST_RUN;
        end
      endcase

      if (load_bubble) begin
        valid_next  = 1'b0;
        inst_next   = NOP_INST;
        bubble_next = 1'b1;
        cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_RUN;
      drain_reg  <= 2'd0;
      valid_reg  <= 1'b0;
      pc_reg     <= '0;
      inst_reg   <= NOP_INST;
      bubble_reg <= 1'b1;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      drain_reg  <= drain_next;
      valid_reg  <= valid_next;
      pc_reg     <= pc_next;
      inst_reg   <= inst_next;
      bubble_reg <= bubble_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign id_valid   = valid_reg;
  assign id_pc      = pc_reg;
  assign id_inst    = inst_reg;
  assign id_bubble  = bubble_reg;
  assign bubble_cnt = cnt_reg;

endmodule
